// File: rtl/pe_operand_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// pe_seq_pkg
// Shared definitions for the PE operand sequencer slice.
//   seq_state_t    : sequencer FSM state (2-bit enum)
//   PE_PIPE_DEPTH  : stage count of the multiply-accumulate PE being driven
//   START_OFFSET   : cycles from a job's first PE beat to its start pulse
// ---------------------------------------------------------------------------
package pe_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  localparam int PE_PIPE_DEPTH = 3;

  // The PE samples start unregistered in its accumulate stage, which sits
  // two cycles behind the operand beat, so start trails the first beat by 2.
  localparam int START_OFFSET = 2;

endpackage

// File: rtl/pe_operand_sequencer_if.sv
// ---------------------------------------------------------------------------
// pe_operand_sequencer_if
// Bundles the command handshake, both operand memory read ports, the PE
// beat stream and the result port of one sequencer.
//   master : the sequencer side (drives ready, read strobes, PE beats, result)
//   slave  : the environment side (controller, memories, PE)
// ---------------------------------------------------------------------------
interface pe_operand_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 8
);

  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [LEN_WIDTH-1:0]    cmd_len;
  logic [ADDR_WIDTH-1:0]   cmd_a_base;
  logic [ADDR_WIDTH-1:0]   cmd_b_base;
  logic [ADDR_WIDTH-1:0]   cmd_b_stride;

  logic                    a_rd_en;
  logic                    b_rd_en;
  logic [ADDR_WIDTH-1:0]   a_rd_addr;
  logic [ADDR_WIDTH-1:0]   b_rd_addr;
  logic [DATA_WIDTH-1:0]   a_rd_data;
  logic [DATA_WIDTH-1:0]   b_rd_data;

  logic                    pe_valid_in;
  logic                    pe_start;
  logic                    pe_last;
  logic [DATA_WIDTH-1:0]   pe_a;
  logic [DATA_WIDTH-1:0]   pe_b;
  logic [2*DATA_WIDTH-1:0] pe_c;
  logic                    pe_output_valid;

  logic [2*DATA_WIDTH-1:0] result;
  logic                    result_valid;

  modport master (
    input  cmd_valid, cmd_len, cmd_a_base, cmd_b_base, cmd_b_stride,
    input  a_rd_data, b_rd_data, pe_c, pe_output_valid,
    output cmd_ready, a_rd_en, b_rd_en, a_rd_addr, b_rd_addr,
    output pe_valid_in, pe_start, pe_last, pe_a, pe_b,
    output result, result_valid
  );

  modport slave (
    output cmd_valid, cmd_len, cmd_a_base, cmd_b_base, cmd_b_stride,
    output a_rd_data, b_rd_data, pe_c, pe_output_valid,
    input  cmd_ready, a_rd_en, b_rd_en, a_rd_addr, b_rd_addr,
    input  pe_valid_in, pe_start, pe_last, pe_a, pe_b,
    input  result, result_valid
  );

endinterface

// File: rtl/pe_operand_sequencer_addr_gen.sv
// ---------------------------------------------------------------------------
// pe_seq_addr_gen
// Strided address generator: load captures a base and a stride, each step
// adds the stride to the current address (wrapping modulo 2^ADDR_WIDTH).
//   i_clk, i_clr : clock, synchronous active-high reset
//   i_load       : capture i_base / i_stride
//   i_base       : first address
//   i_stride     : per-step increment
//   i_step       : advance to the next address
//   o_addr       : current address
// ---------------------------------------------------------------------------
module pe_seq_addr_gen #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_clr,
  input  logic                  i_load,
  input  logic [ADDR_WIDTH-1:0] i_base,
  input  logic [ADDR_WIDTH-1:0] i_stride,
  input  logic                  i_step,
  output logic [ADDR_WIDTH-1:0] o_addr
);

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_stride;

  // Running-sum address register. A load and a step never coincide because
  // the sequencer only loads while idle and only steps while issuing; load
  // is still given priority so a fresh job always starts at its base.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_addr   <= '0;
      r_stride <= '0;
    end else if (i_load) begin
      r_addr   <= i_base;
      r_stride <= i_stride;
    end else if (i_step) begin
      r_addr   <= r_addr + r_stride;
    end
  end

  assign o_addr = r_addr;

endmodule

// File: rtl/pe_operand_sequencer.sv
// ---------------------------------------------------------------------------
// pe_operand_sequencer
// Runs one dot-product job through a three-stage multiply-accumulate PE:
// reads N operand pairs from the A/B memories, streams them to the PE with
// valid/last/start aligned to the PE pipeline, and captures the PE result.
//   i_clk  : clock, rising edge
//   i_clr  : synchronous active-high reset
//   io_bus : master side of pe_operand_sequencer_if (command handshake,
//            A/B memory read ports, PE beat stream, result/result_valid)
// ---------------------------------------------------------------------------
module pe_operand_sequencer
  import pe_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_clr,
  pe_operand_sequencer_if.master io_bus
);

  // One cycle from accept to first read, one from read to beat, then
  // START_OFFSET more from the first beat to the start pulse.
  localparam int START_PIPE_LEN = START_OFFSET + 2;

  seq_state_t              r_state;
  logic [LEN_WIDTH-1:0]    r_remaining;
  logic                    r_cmdReady;
  logic                    r_rdEn;
  logic                    r_peValid;
  logic                    r_peLast;
  logic [START_PIPE_LEN-1:0] r_startPipe;
  logic [2*DATA_WIDTH-1:0] r_result;
  logic                    r_resultValid;

  logic                    w_accept;
  logic                    w_acceptJob;
  logic                    w_lastIssue;
  logic [ADDR_WIDTH-1:0]   w_aAddr;
  logic [ADDR_WIDTH-1:0]   w_bAddr;

  assign w_accept    = r_cmdReady & io_bus.cmd_valid;
  assign w_acceptJob = w_accept & (io_bus.cmd_len != '0);
  assign w_lastIssue = (r_state == ISSUE) && (r_remaining == LEN_WIDTH'(1));

  // Main job FSM. Ready is registered and only ever high in IDLE, so it is
  // low for the first cycle out of reset and drops the cycle after accept.
  // A zero-length command skips the memories and the PE entirely and
  // reports a zero result straight away.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_state       <= IDLE;
      r_remaining   <= '0;
      r_cmdReady    <= 1'b0;
      r_rdEn        <= 1'b0;
      r_result      <= '0;
      r_resultValid <= 1'b0;
    end else begin
      r_resultValid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_cmdReady <= 1'b0;
            if (io_bus.cmd_len == '0) begin
              r_result      <= '0;
              r_resultValid <= 1'b1;
              r_state       <= DONE;
            end else begin
              r_remaining <= io_bus.cmd_len;
              r_rdEn      <= 1'b1;
              r_state     <= ISSUE;
            end
          end else begin
            r_cmdReady <= 1'b1;
          end
        end
        ISSUE: begin
          r_remaining <= r_remaining - LEN_WIDTH'(1);
          if (w_lastIssue) begin
            r_rdEn  <= 1'b0;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (io_bus.pe_output_valid) begin
            r_result      <= io_bus.pe_c;
            r_resultValid <= 1'b1;
            r_state       <= DONE;
          end
        end
        DONE: begin
          r_cmdReady <= 1'b1;
          r_state    <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // PE beat alignment. Memory data arrives one cycle after the read strobe,
  // so valid and last are the strobe and last-issue flag delayed by one.
  // The start pulse is the job accept shifted down a short pipe so it lands
  // START_OFFSET cycles after the first beat, regardless of job length.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_peValid   <= 1'b0;
      r_peLast    <= 1'b0;
      r_startPipe <= '0;
    end else begin
      r_peValid   <= r_rdEn;
      r_peLast    <= w_lastIssue;
      r_startPipe <= {r_startPipe[START_PIPE_LEN-2:0], w_acceptJob};
    end
  end

  pe_seq_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_aAddrGen (
    .i_clk    (i_clk),
    .i_clr    (i_clr),
    .i_load   (w_acceptJob),
    .i_base   (io_bus.cmd_a_base),
    .i_stride (ADDR_WIDTH'(1)),
    .i_step   (r_rdEn),
    .o_addr   (w_aAddr)
  );

  pe_seq_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_bAddrGen (
    .i_clk    (i_clk),
    .i_clr    (i_clr),
    .i_load   (w_acceptJob),
    .i_base   (io_bus.cmd_b_base),
    .i_stride (io_bus.cmd_b_stride),
    .i_step   (r_rdEn),
    .o_addr   (w_bAddr)
  );

  assign io_bus.cmd_ready    = r_cmdReady;
  assign io_bus.a_rd_en      = r_rdEn;
  assign io_bus.b_rd_en      = r_rdEn;
  assign io_bus.a_rd_addr    = w_aAddr;
  assign io_bus.b_rd_addr    = w_bAddr;
  assign io_bus.pe_valid_in  = r_peValid;
  assign io_bus.pe_last      = r_peLast;
  assign io_bus.pe_start     = r_startPipe[START_PIPE_LEN-1];
  assign io_bus.pe_a         = io_bus.a_rd_data;
  assign io_bus.pe_b         = io_bus.b_rd_data;
  assign io_bus.result       = r_result;
  assign io_bus.result_valid = r_resultValid;

endmodule

// File: tb/tb_pe_operand_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pe_operand_sequencer
// Directed bench: 1-cycle-latency A/B memories, a behavioural three-stage
// MAC PE, and hand-computed expectations for each job.
// ---------------------------------------------------------------------------
module tb_pe_operand_sequencer;

  logic clk;
  logic clr;

  int assertCount = 0;
  int failCount   = 0;

  pe_operand_sequencer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .LEN_WIDTH(8)) bus ();

  pe_operand_sequencer #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .LEN_WIDTH(8)) dut (
    .i_clk  (clk),
    .i_clr  (clr),
    .io_bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Operand memories: synchronous read, data valid the cycle after rd_en.
  logic [31:0] memA [0:1023];
  logic [31:0] memB [0:1023];

  always_ff @(posedge clk) begin
    if (bus.a_rd_en) bus.a_rd_data <= memA[bus.a_rd_addr];
    if (bus.b_rd_en) bus.b_rd_data <= memB[bus.b_rd_addr];
  end

  // Behavioural PE: operand register, multiply stage, accumulate stage.
  // start is sampled unregistered in the accumulate stage and restarts the sum.
  logic        s1V, s1Last, s2V, s2Last;
  logic [31:0] s1A, s1B;
  logic [63:0] s2P, peAcc;
  logic [63:0] peSum;

  assign peSum = (bus.pe_start ? 64'd0 : peAcc) + s2P;

  always_ff @(posedge clk) begin
    if (clr) begin
      s1V <= 1'b0; s1Last <= 1'b0; s2V <= 1'b0; s2Last <= 1'b0;
      s1A <= '0; s1B <= '0; s2P <= '0; peAcc <= '0;
      bus.pe_c <= '0; bus.pe_output_valid <= 1'b0;
    end else begin
      s1V    <= bus.pe_valid_in;
      s1Last <= bus.pe_valid_in & bus.pe_last;
      s1A    <= bus.pe_a;
      s1B    <= bus.pe_b;
      s2V    <= s1V;
      s2Last <= s1Last;
      s2P    <= 64'(s1A) * 64'(s1B);
      bus.pe_output_valid <= 1'b0;
      if (s2V) begin
        peAcc <= peSum;
        if (s2Last) begin
          bus.pe_c            <= peSum;
          bus.pe_output_valid <= 1'b1;
        end
      end
    end
  end

  // Per-job observations, filled by applyStimulus.
  int aLog[$];
  int bLog[$];
  int rdCount, firstRd, lastRd, strobeSkew;
  int validCount, firstValid, lastValid;
  int lastCount, lastCycle, startCount, startCycle;
  int rvCycle, readyDuring, readyAfter, waitCycles;
  longint rvResult;

  task automatic checkOutput(input string tag, input longint actual, input longint expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Must be entered right after a negedge. Waits (bounded) for ready, offers
  // the command in that cycle (cycle 0), then watches cycles 1.. at negedges
  // until the cycle after result_valid.
  task automatic applyStimulus(input int len, input int aBase, input int bBase, input int stride);
    waitCycles = 0;
    while (!bus.cmd_ready && waitCycles < 50) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!bus.cmd_ready) checkOutput("readyTimeout", 0, 1);
    bus.cmd_len      = 8'(len);
    bus.cmd_a_base   = 10'(aBase);
    bus.cmd_b_base   = 10'(bBase);
    bus.cmd_b_stride = 10'(stride);
    bus.cmd_valid    = 1'b1;
    aLog.delete(); bLog.delete();
    rdCount = 0; firstRd = -1; lastRd = -1; strobeSkew = 0;
    validCount = 0; firstValid = -1; lastValid = -1;
    lastCount = 0; lastCycle = -1; startCount = 0; startCycle = -1;
    rvCycle = -1; readyDuring = 0; readyAfter = 0; rvResult = -1;
    @(posedge clk);
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (k == 1) bus.cmd_valid = 1'b0;
      if (bus.a_rd_en) begin
        rdCount++;
        aLog.push_back(int'(bus.a_rd_addr));
        bLog.push_back(int'(bus.b_rd_addr));
        if (firstRd < 0) firstRd = k;
        lastRd = k;
      end
      if (bus.a_rd_en != bus.b_rd_en) strobeSkew++;
      if (bus.pe_valid_in) begin
        validCount++;
        if (firstValid < 0) firstValid = k;
        lastValid = k;
      end
      if (bus.pe_last)  begin lastCount++;  lastCycle  = k; end
      if (bus.pe_start) begin startCount++; startCycle = k; end
      if (rvCycle >= 0) begin
        readyAfter = int'(bus.cmd_ready);
        break;
      end
      if (bus.cmd_ready) readyDuring = 1;
      if (bus.result_valid) begin
        rvCycle  = k;
        rvResult = longint'(bus.result);
      end
    end
  endtask

  task automatic checkJob(input string tag, input int len, input longint expResult);
    checkOutput({tag, "_rvCycle"},    rvCycle,    (len == 0) ? 1 : len + 5);
    checkOutput({tag, "_result"},     rvResult,   expResult);
    checkOutput({tag, "_readyAfter"}, readyAfter, 1);
    checkOutput({tag, "_readyBusy"},  readyDuring, 0);
    checkOutput({tag, "_rdCount"},    rdCount,    len);
    checkOutput({tag, "_firstRd"},    firstRd,    (len == 0) ? -1 : 1);
    checkOutput({tag, "_lastRd"},     lastRd,     (len == 0) ? -1 : len);
    checkOutput({tag, "_strobeSkew"}, strobeSkew, 0);
    checkOutput({tag, "_validCount"}, validCount, len);
    checkOutput({tag, "_firstValid"}, firstValid, (len == 0) ? -1 : 2);
    checkOutput({tag, "_lastValid"},  lastValid,  (len == 0) ? -1 : len + 1);
    checkOutput({tag, "_lastCount"},  lastCount,  (len == 0) ? 0 : 1);
    checkOutput({tag, "_lastCycle"},  lastCycle,  (len == 0) ? -1 : len + 1);
    checkOutput({tag, "_startCount"}, startCount, (len == 0) ? 0 : 1);
    checkOutput({tag, "_startCycle"}, startCycle, (len == 0) ? -1 : 4);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_rdEn"},        bus.a_rd_en | bus.b_rd_en, 0);
    checkOutput({tag, "_aAddr"},       bus.a_rd_addr, 0);
    checkOutput({tag, "_bAddr"},       bus.b_rd_addr, 0);
    checkOutput({tag, "_peValid"},     bus.pe_valid_in, 0);
    checkOutput({tag, "_peStart"},     bus.pe_start, 0);
    checkOutput({tag, "_peLast"},      bus.pe_last, 0);
    checkOutput({tag, "_result"},      longint'(bus.result), 0);
    checkOutput({tag, "_resultValid"}, bus.result_valid, 0);
    checkOutput({tag, "_cmdReady"},    bus.cmd_ready, 0);
  endtask

  // Hard stop so a hung DUT can never stall the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int expA[4];
    int expB[4];
    for (int i = 0; i < 1024; i++) begin
      memA[i] = 32'(i + 1000);
      memB[i] = 32'(i + 2000);
    end
    clr = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_len = '0; bus.cmd_a_base = '0; bus.cmd_b_base = '0; bus.cmd_b_stride = '0;

    $display("[TB] reset state");
    repeat (3) @(negedge clk);
    checkIdleOutputs("reset");
    clr = 1'b0;
    @(negedge clk);
    checkOutput("readyAfterReset", bus.cmd_ready, 1);

    $display("[TB] N=4 basic dot product");
    memA[0] = 1; memA[1] = 2; memA[2] = 3; memA[3] = 4;
    memB[0] = 5; memB[4] = 6; memB[8] = 7; memB[12] = 8;
    applyStimulus(4, 0, 0, 4);
    checkJob("n4", 4, 70);
    expA = '{0, 1, 2, 3};
    expB = '{0, 4, 8, 12};
    checkOutput("n4_addrCount", aLog.size(), 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("n4_aAddr%0d", i), (i < aLog.size()) ? aLog[i] : -1, expA[i]);
      checkOutput($sformatf("n4_bAddr%0d", i), (i < bLog.size()) ? bLog[i] : -1, expB[i]);
    end

    $display("[TB] back-to-back jobs");
    memA[100] = 3; memA[101] = 4;
    memB[200] = 10; memB[201] = 11;
    memA[300] = 2; memA[301] = 5; memA[302] = 7;
    memB[400] = 1; memB[402] = 3; memB[404] = 4;
    applyStimulus(2, 100, 200, 1);
    checkJob("b2bFirst", 2, 74);
    applyStimulus(3, 300, 400, 2);
    checkOutput("b2b_waitCycles", waitCycles, 0);
    checkJob("b2bSecond", 3, 45);

    $display("[TB] N=1 single element");
    memA[50] = 7; memB[60] = 9;
    applyStimulus(1, 50, 60, 3);
    checkJob("n1", 1, 63);

    $display("[TB] N=0 empty job");
    applyStimulus(0, 5, 5, 1);
    checkJob("n0", 0, 0);

    $display("[TB] address wrap");
    memA[1022] = 1; memA[1023] = 2; memA[0] = 3; memA[1] = 4;
    memB[1000] = 2; memB[1012] = 3; memB[0] = 4; memB[12] = 5;
    applyStimulus(4, 1022, 1000, 12);
    checkJob("wrap", 4, 40);
    expA = '{1022, 1023, 0, 1};
    expB = '{1000, 1012, 0, 12};
    checkOutput("wrap_addrCount", aLog.size(), 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("wrap_aAddr%0d", i), (i < aLog.size()) ? aLog[i] : -1, expA[i]);
      checkOutput($sformatf("wrap_bAddr%0d", i), (i < bLog.size()) ? bLog[i] : -1, expB[i]);
    end

    $display("[TB] reset during N=8 job");
    checkOutput("preClr_ready", bus.cmd_ready, 1);
    bus.cmd_len = 8'd8; bus.cmd_a_base = 10'd0; bus.cmd_b_base = 10'd0; bus.cmd_b_stride = 10'd1;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    checkOutput("midJob_rdEn", bus.a_rd_en, 1);
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    checkIdleOutputs("clr");
    clr = 1'b0;
    @(negedge clk);
    checkOutput("clr_readyAfter", bus.cmd_ready, 1);
    memA[700] = 6; memA[701] = 5;
    memB[800] = 3; memB[810] = 2;
    applyStimulus(2, 700, 800, 10);
    checkJob("postClr", 2, 28);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/pe_operand_sequencer.md
# pe_operand_sequencer

Drives one dot-product job into a three-stage multiply-accumulate PE and collects the result. Takes a command (vector length, A/B base addresses, B stride) and reads A and B operands from two synchronous-read operand memories, one element per cycle. It issues the PE's `valid_in`/`start`/`last`/`a`/`b` stream with the PE's pipeline alignment and captures the PE's `c` on `output_valid`. It sits between the matrix-multiplier controller and each PE.

## Interface
Parameters:
- `DATA_WIDTH`, 32, operand width; result is `2*DATA_WIDTH`
- `ADDR_WIDTH`, 10, operand memory address width
- `LEN_WIDTH`, 8, vector-length field width

Ports:
- `clk`  in  1  single clock, rising edge
- `clr`  in  1  synchronous, active-high reset
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  command accepted when both high
- `cmd_len`  in  LEN_WIDTH  element count N
- `cmd_a_base`  in  ADDR_WIDTH  A start address (stride 1)
- `cmd_b_base`  in  ADDR_WIDTH  B start address
- `cmd_b_stride`  in  ADDR_WIDTH  B address increment per element
- `a_rd_en`, `b_rd_en`  out  1  memory read strobes
- `a_rd_addr`, `b_rd_addr`  out  ADDR_WIDTH  read addresses
- `a_rd_data`, `b_rd_data`  in  DATA_WIDTH  read data, valid the cycle after `rd_en`
- `pe_valid_in`, `pe_start`, `pe_last`  out  1  PE control
- `pe_a`, `pe_b`  out  DATA_WIDTH  PE operands
- `pe_c`  in  2*DATA_WIDTH  PE accumulator
- `pe_output_valid`  in  1  PE result valid
- `result`  out  2*DATA_WIDTH  captured dot product
- `result_valid`  out  1  one-cycle pulse; doubles as job done

## Operation
- States: IDLE, ISSUE, WAIT, DONE. Encoding: 2-bit enum.
- IDLE: `cmd_ready`=1. On `cmd_valid` with N≥1, latch fields and go to ISSUE. On `cmd_valid` with N=0, go to DONE with `result`=0, and emit no PE beats.
- ISSUE: assert `a_rd_en`/`b_rd_en` for N consecutive cycles.
  - Element k address: A = `a_base+k`; B = `b_base+k*b_stride`, built as a running sum.
  - All address arithmetic is modulo 2^ADDR_WIDTH, so it wraps silently.
  - After element N-1 is issued, go to WAIT.
- Beat generation:
  - `pe_valid_in` is `rd_en` delayed one cycle.
  - `pe_a`/`pe_b` pass `a_rd_data`/`b_rd_data` straight through, with no register.
  - `pe_last` is high with the beat for element N-1.
  - `pe_a`/`pe_b` are don't-care when `pe_valid_in`=0.
- `pe_start`: one-cycle pulse exactly 2 cycles after the first `pe_valid_in` of the job. The PE samples `start` unpipelined in its accumulate stage, so this aligns it with the first product.
- WAIT: on `pe_output_valid`, capture `pe_c` into `result` and go to DONE. `pe_output_valid` is ignored in every other state. WAIT has no timeout.
- DONE: `result_valid`=1 for one cycle, then go to IDLE. `result` holds until the next capture.
- A reset at any time forces IDLE and zeroes all registered outputs. An in-flight PE job is abandoned; the controller resets the PE as well.

## Timing
- Reset values: `cmd_ready`=0 during reset and 1 the first cycle after. All other outputs are 0.
- Command accepted at cycle 0, N≥1:
  - `rd_en` high during cycles 1..N.
  - `pe_valid_in` high during cycles 2..N+1.
  - `pe_last` high at cycle N+1.
  - `pe_start` high at cycle 4.
  - `pe_output_valid` is expected at cycle N+4.
  - `result_valid` high at cycle N+5.
  - `cmd_ready` high again at cycle N+6.
- N=0: `result_valid` high at cycle 1, `cmd_ready` high at cycle 2.
- Maximum throughput: one job per N+6 cycles. Jobs do not overlap.

## Structure
- Shared package `pe_seq_pkg` holds:
  - the state enum type
  - the `PE_PIPE_DEPTH`=3 constant
  - the `START_OFFSET`=2 constant, from which `pe_start` alignment is derived
- One sub-module, `pe_seq_addr_gen`: loads a base and a stride, steps on an enable, and outputs the current address. It is instantiated twice, with stride 1 for A and `cmd_b_stride` for B.

## Test plan
Bench: 1-cycle-latency memory models plus the real PE.
- N=4, A[0..3]=1,2,3,4, B base 0 stride 4 holding 5,6,7,8 → B addresses 0,4,8,12; `pe_start` at cycle 4; `result`=70 with `result_valid` at cycle 9.
- Two back-to-back jobs (N=2 → 70-style values, then N=3) → `cmd_ready` low throughout the first job; the second `pe_start` aligns to its own first beat; results are independent.
- N=1, A=7, B=9 → `pe_last` and `pe_valid_in` both at cycle 2, `pe_start` at cycle 4, `result`=63 at cycle 6.
- N=0 → no `rd_en`, no `pe_valid_in`; `result`=0 and `result_valid` at cycle 1.
- `a_base`=1022, `b_base`=1000, `b_stride`=12, N=4 → A addresses 1022,1023,0,1; B addresses 1000,1012,0,12.
- `clr` asserted at cycle 3 of an N=8 job → all outputs 0 the next cycle, `cmd_ready`=1 after `clr` is released, and a new job completes correctly.
